// File: rtl/vga_fbread_pkg.sv
// Shared VGA display constants: default 640x480@60 timing, display size,
// bus widths and the pixel word layout used by the display blocks.
package vga_fbread_pkg;

    localparam int unsigned H_FRONT_DEF  = 16;
    localparam int unsigned H_WIDTH_DEF  = 96;
    localparam int unsigned H_BACK_DEF   = 48;
    localparam int unsigned H_PERIOD_DEF = 800;
    localparam int unsigned V_FRONT_DEF  = 10;
    localparam int unsigned V_WIDTH_DEF  = 2;
    localparam int unsigned V_BACK_DEF   = 33;
    localparam int unsigned V_PERIOD_DEF = 525;

    localparam int unsigned H_ACTIVE     = 640;
    localparam int unsigned V_ACTIVE     = 480;
    localparam int unsigned FRAME_PIXELS = H_ACTIVE * V_ACTIVE;   // 307200, also buffer 1 base

    localparam int unsigned ADDR_W = 20;
    localparam int unsigned OFFS_W = 19;
    localparam int unsigned CHAN_W = 4;
    localparam int unsigned RGB_W  = 3 * CHAN_W;

    // Frame memory word {R,G,B}
    typedef struct packed {
        logic [CHAN_W-1:0] r;
        logic [CHAN_W-1:0] g;
        logic [CHAN_W-1:0] b;
    } rgb_t;

endpackage

// File: rtl/vga_timing.sv
// Pixel-enable divider and H/V counters with stage-0 sync/display decodes.
// Ports: clk_i, rst_ni (async active-low); pen_c_o pixel enable (1 in 4 clk);
// frame_top_c_o counters at (0,0); hs_act_c_o / vs_act_c_o sync active;
// disp_c_o counters inside the display region. All _c_o are decodes of
// registered counters.
module vga_timing
    import vga_fbread_pkg::*;
#(
    parameter int unsigned HFRONT  = H_FRONT_DEF,
    parameter int unsigned HWIDTH  = H_WIDTH_DEF,
    parameter int unsigned HBACK   = H_BACK_DEF,
    parameter int unsigned HPERIOD = H_PERIOD_DEF,
    parameter int unsigned VFRONT  = V_FRONT_DEF,
    parameter int unsigned VWIDTH  = V_WIDTH_DEF,
    parameter int unsigned VBACK   = V_BACK_DEF,
    parameter int unsigned VPERIOD = V_PERIOD_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic pen_c_o,
    output logic frame_top_c_o,
    output logic hs_act_c_o,
    output logic vs_act_c_o,
    output logic disp_c_o
);

    localparam int unsigned HW = $clog2(HPERIOD);
    localparam int unsigned VW = $clog2(VPERIOD);

    localparam logic [HW-1:0] H_SYNC_S = HW'(HFRONT);
    localparam logic [HW-1:0] H_SYNC_E = HW'(HFRONT + HWIDTH);
    localparam logic [HW-1:0] H_DISP_S = HW'(HFRONT + HWIDTH + HBACK);
    localparam logic [HW-1:0] H_LAST   = HW'(HPERIOD - 1);
    localparam logic [VW-1:0] V_SYNC_S = VW'(VFRONT);
    localparam logic [VW-1:0] V_SYNC_E = VW'(VFRONT + VWIDTH);
    localparam logic [VW-1:0] V_DISP_S = VW'(VFRONT + VWIDTH + VBACK);
    localparam logic [VW-1:0] V_LAST   = VW'(VPERIOD - 1);

    logic [1:0]    div_q;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [VW-1:0] vcnt_q, vcnt_d;

    // First enable lands on the 4th edge after reset release
    assign pen_c_o       = (div_q == 2'd3);
    assign frame_top_c_o = (hcnt_q == '0) && (vcnt_q == '0);
    assign hs_act_c_o    = (hcnt_q >= H_SYNC_S) && (hcnt_q < H_SYNC_E);
    assign vs_act_c_o    = (vcnt_q >= V_SYNC_S) && (vcnt_q < V_SYNC_E);
    assign disp_c_o      = (hcnt_q >= H_DISP_S) && (vcnt_q >= V_DISP_S);

    // Raster counter advance
    always_comb begin
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        if (pen_c_o) begin
            if (hcnt_q == H_LAST) begin
                hcnt_d = '0;
                vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + VW'(1);
            end else begin
                hcnt_d = hcnt_q + HW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q  <= 2'd0;
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else begin
            div_q  <= div_q + 2'd1;
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
        end
    end

endmodule

// File: rtl/vga_fbread.sv
// Frame-buffer reader: issues one memory read per display pixel and drives
// VGA colour/syncs through a 2-pixel pipeline.
// Ports: CLK, RST (async active-low); FRAME_SEL buffer request sampled at
// frame start; RADDR read address; RDATA word valid one CLK after RADDR;
// VGA_R/G/B colour; VGA_HS/VGA_VS active-low syncs; FRAME_START pulse.
module vga_fbread
    import vga_fbread_pkg::*;
#(
    parameter int unsigned HFRONT  = H_FRONT_DEF,
    parameter int unsigned HWIDTH  = H_WIDTH_DEF,
    parameter int unsigned HBACK   = H_BACK_DEF,
    parameter int unsigned HPERIOD = H_PERIOD_DEF,
    parameter int unsigned VFRONT  = V_FRONT_DEF,
    parameter int unsigned VWIDTH  = V_WIDTH_DEF,
    parameter int unsigned VBACK   = V_BACK_DEF,
    parameter int unsigned VPERIOD = V_PERIOD_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              FRAME_SEL,
    output logic [ADDR_W-1:0] RADDR,
    input  logic [RGB_W-1:0]  RDATA,
    output logic [CHAN_W-1:0] VGA_R,
    output logic [CHAN_W-1:0] VGA_G,
    output logic [CHAN_W-1:0] VGA_B,
    output logic              VGA_HS,
    output logic              VGA_VS,
    output logic              FRAME_START
);

    localparam int unsigned DISP_PIX =
        (HPERIOD - (HFRONT + HWIDTH + HBACK)) * (VPERIOD - (VFRONT + VWIDTH + VBACK));
    localparam logic [OFFS_W-1:0] OFFS_LAST = OFFS_W'(DISP_PIX - 1);

    logic pen, frame_top, hs_act0, vs_act0, disp0;

    vga_timing #(
        .HFRONT (HFRONT),  .HWIDTH (HWIDTH),  .HBACK (HBACK),  .HPERIOD (HPERIOD),
        .VFRONT (VFRONT),  .VWIDTH (VWIDTH),  .VBACK (VBACK),  .VPERIOD (VPERIOD)
    ) u_timing (
        .clk_i         (CLK),
        .rst_ni        (RST),
        .pen_c_o       (pen),
        .frame_top_c_o (frame_top),
        .hs_act_c_o    (hs_act0),
        .vs_act_c_o    (vs_act0),
        .disp_c_o      (disp0)
    );

    logic              buf_q, buf_d;
    logic [OFFS_W-1:0] offset_q, offset_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic              hs_act1_q, hs_act1_d;   // stage-1 flags held active-high so reset is all-zero
    logic              vs_act1_q, vs_act1_d;
    logic              disp1_q, disp1_d;
    rgb_t              rgb_q, rgb_d;
    logic              hs_n_q, hs_n_d;
    logic              vs_n_q, vs_n_d;
    logic              fs_q, fs_d;

    // Address generation and output pipeline, all advancing on pixel enable
    always_comb begin
        buf_d     = buf_q;
        offset_d  = offset_q;
        raddr_d   = raddr_q;
        hs_act1_d = hs_act1_q;
        vs_act1_d = vs_act1_q;
        disp1_d   = disp1_q;
        rgb_d     = rgb_q;
        hs_n_d    = hs_n_q;
        vs_n_d    = vs_n_q;
        fs_d      = 1'b0;
        if (pen) begin
            if (frame_top) begin
                buf_d    = FRAME_SEL;
                offset_d = '0;
                fs_d     = 1'b1;
            end
            if (disp0) begin
                raddr_d  = (buf_q ? ADDR_W'(FRAME_PIXELS) : '0) + ADDR_W'(offset_q);
                offset_d = (offset_q == OFFS_LAST) ? '0 : offset_q + OFFS_W'(1);
            end
            hs_act1_d = hs_act0;
            vs_act1_d = vs_act0;
            disp1_d   = disp0;
            // RDATA now holds the word for the stage-1 pixel
            rgb_d     = disp1_q ? rgb_t'(RDATA) : '0;
            hs_n_d    = ~hs_act1_q;
            vs_n_d    = ~vs_act1_q;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            buf_q     <= 1'b0;
            offset_q  <= '0;
            raddr_q   <= '0;
            hs_act1_q <= 1'b0;
            vs_act1_q <= 1'b0;
            disp1_q   <= 1'b0;
            rgb_q     <= '0;
            hs_n_q    <= 1'b1;
            vs_n_q    <= 1'b1;
            fs_q      <= 1'b0;
        end else begin
            buf_q     <= buf_d;
            offset_q  <= offset_d;
            raddr_q   <= raddr_d;
            hs_act1_q <= hs_act1_d;
            vs_act1_q <= vs_act1_d;
            disp1_q   <= disp1_d;
            rgb_q     <= rgb_d;
            hs_n_q    <= hs_n_d;
            vs_n_q    <= vs_n_d;
            fs_q      <= fs_d;
        end
    end

    assign RADDR       = raddr_q;
    assign VGA_R       = rgb_q.r;
    assign VGA_G       = rgb_q.g;
    assign VGA_B       = rgb_q.b;
    assign VGA_HS      = hs_n_q;
    assign VGA_VS      = vs_n_q;
    assign FRAME_START = fs_q;

endmodule

// File: tb/tb_vga_fbread.sv
// Bench for vga_fbread using a reduced raster (16x10 total, 8x5 visible) so
// many frames fit in a short run. The reference derives every pixel's
// expected sync/colour/address from its raster position.
module tb_vga_fbread;

    localparam int HF = 2, HWD = 3, HB = 3, HP = 16;
    localparam int VF = 1, VWD = 2, VB = 2, VP = 10;
    localparam int HS0 = HF + HWD + HB;
    localparam int VS0 = VF + VWD + VB;
    localparam int DW = HP - HS0;
    localparam int NPIX = HP * VP;
    localparam int BASE1 = 307200;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        frame_sel = 1'b0;
    logic [19:0] raddr;
    logic [11:0] rdata = 12'h000;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        vga_hs, vga_vs, frame_start;

    int n_checks = 0;
    int n_errors = 0;
    int e = 0;
    logic [31:0] seed;

    int n, p, q, prev;
    int m_raddr = 0;
    bit m_buf = 1'b0;
    bit exp_hs = 1'b1, exp_vs = 1'b1, exp_fs;
    logic [11:0] exp_rgb = 12'h000;
    int hs_cnt = 0, vs_cnt = 0;

    vga_fbread #(
        .HFRONT (HF), .HWIDTH (HWD), .HBACK (HB), .HPERIOD (HP),
        .VFRONT (VF), .VWIDTH (VWD), .VBACK (VB), .VPERIOD (VP)
    ) dut (
        .CLK         (clk),
        .RST         (rst_n),
        .FRAME_SEL   (frame_sel),
        .RADDR       (raddr),
        .RDATA       (rdata),
        .VGA_R       (vga_r),
        .VGA_G       (vga_g),
        .VGA_B       (vga_b),
        .VGA_HS      (vga_hs),
        .VGA_VS      (vga_vs),
        .FRAME_START (frame_start)
    );

    initial forever #5 clk = ~clk;

    // Image content: pseudo-random word per address
    function automatic logic [11:0] img_of(input logic [19:0] a);
        logic [31:0] t;
        t = ({12'b0, a} * 32'd2654435761) ^ seed;
        return t[23:12];
    endfunction

    function automatic bit is_disp(input int pp);
        return ((pp % HP) >= HS0) && ((pp / HP) >= VS0);
    endfunction
    function automatic int pix_off(input int pp);
        return ((pp / HP) - VS0) * DW + (pp % HP) - HS0;
    endfunction
    function automatic bit hs_low(input int pp);
        return ((pp % HP) >= HF) && ((pp % HP) < HF + HWD);
    endfunction
    function automatic bit vs_low(input int pp);
        return ((pp / HP) >= VF) && ((pp / HP) < VF + VWD);
    endfunction

    // Frame memory: one-cycle read latency
    always @(posedge clk) rdata <= img_of(raddr);

    // Clock edges since reset release
    always @(posedge clk) begin
        if (!rst_n) e = 0;
        else        e = e + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_raddr"}, 32'(raddr), 32'd0);
        check({tag, "_rgb"}, 32'({vga_r, vga_g, vga_b}), 32'd0);
        check({tag, "_hs"}, 32'(vga_hs), 32'd1);
        check({tag, "_vs"}, 32'(vga_vs), 32'd1);
        check({tag, "_fs"}, 32'(frame_start), 32'd0);
    endtask

    // Compare process: model update on each pixel enable, check every cycle
    always @(negedge clk) begin
        if (!rst_n) begin
            m_raddr = 0; m_buf = 1'b0; exp_hs = 1'b1; exp_vs = 1'b1; exp_rgb = 12'h000;
            hs_cnt = 0; vs_cnt = 0;
        end else if (e >= 4 && (e % 4) == 0) begin
            n = e / 4 - 1;
            p = n % NPIX;
            prev = m_raddr;
            if (p == 0) m_buf = frame_sel;
            if (is_disp(p)) m_raddr = (m_buf ? BASE1 : 0) + pix_off(p);
            if (n == 0) begin
                exp_hs = 1'b1; exp_vs = 1'b1; exp_rgb = 12'h000; hs_cnt = 0; vs_cnt = 0;
            end else begin
                q = (n - 1) % NPIX;
                exp_hs  = !hs_low(q);
                exp_vs  = !vs_low(q);
                exp_rgb = is_disp(q) ? img_of(20'(prev)) : 12'h000;
                if (n <= 16 && !vga_hs) hs_cnt++;
                if (n <= NPIX && !vga_vs) vs_cnt++;
            end
            // Hand-computed anchors for the reduced raster
            if (n == 0)   check("lit_first_frame_start", 32'(frame_start), 32'd1);
            if (n == 88)  check("lit_first_addr", 32'(raddr), 32'd0);
            if (n == 89)  check("lit_second_addr", 32'(raddr), 32'd1);
            if (n == 89)  check("lit_first_rgb", 32'({vga_r, vga_g, vga_b}), 32'(img_of(20'd0)));
            if (n == 90)  check("lit_second_rgb", 32'({vga_r, vga_g, vga_b}), 32'(img_of(20'd1)));
            if (n == 16)  check("lit_hs_low_per_line", 32'(hs_cnt), 32'd3);
            if (n == 159) check("lit_frame0_last_addr", 32'(raddr), 32'd39);
            if (n == 160) check("lit_vs_low_per_frame", 32'(vs_cnt), 32'd32);
            if (n == 248) check("lit_frame1_first_addr", 32'(raddr), 32'd307200);
            if (n == 319) check("lit_frame1_last_addr", 32'(raddr), 32'd307239);
        end
        exp_fs = rst_n && e >= 4 && (e % 4) == 0 && (((e / 4) - 1) % NPIX) == 0;
        check("raddr", 32'(raddr), 32'(m_raddr));
        check("rgb", 32'({vga_r, vga_g, vga_b}), 32'(exp_rgb));
        check("hs", 32'(vga_hs), 32'(exp_hs));
        check("vs", 32'(vga_vs), 32'(exp_vs));
        check("frame_start", 32'(frame_start), 32'(exp_fs));
    end

    // Release reset with buffer 0, request buffer 1 on line 7 of frame 0
    task automatic run_from_reset();
        frame_sel = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (452) @(negedge clk);
        #1 frame_sel = 1'b1;
        repeat (900) @(negedge clk);
    endtask

    initial begin
        seed = $urandom;
        #1 rst_n = 1'b0;
        run_from_reset();
        // Random buffer requests across several frames
        repeat (3200) begin
            @(negedge clk);
            #1;
            if ($urandom_range(0, 299) == 0) frame_sel = ~frame_sel;
        end
        // Mid-frame reset must clear outputs immediately
        repeat ($urandom_range(100, 600)) @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check_reset_vals("async_reset");
        run_from_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
